// File: rtl/dds_sin_gen_if.sv
// rtl/dds_sin_gen_if.sv - control/sample bundle for dds_sin_gen; DDS_QUAD_EN adds cos_data
interface dds_sin_gen_if #(
    parameter int DATA_W  = 12,
    parameter int PHASE_W = 24
);
    logic               en;
    logic [PHASE_W-1:0] ftw_in;
    logic               ftw_load;
    logic [DATA_W-1:0]  sin_data;
    logic               sin_valid;
    logic               VSYNC;
`ifdef DDS_QUAD_EN
    logic [DATA_W-1:0]  cos_data;

    modport master (output en, ftw_in, ftw_load,
                    input  sin_data, sin_valid, VSYNC, cos_data);
    modport slave  (input  en, ftw_in, ftw_load,
                    output sin_data, sin_valid, VSYNC, cos_data);
`else
    modport master (output en, ftw_in, ftw_load,
                    input  sin_data, sin_valid, VSYNC);
    modport slave  (input  en, ftw_in, ftw_load,
                    output sin_data, sin_valid, VSYNC);
`endif
endinterface

// File: rtl/dds_sin_gen.sv
// rtl/dds_sin_gen.sv - DDS sine generator: phase accumulator, quarter-wave ROM, 3-stage pipe; DDS_QUAD_EN adds cos_data
module dds_sin_gen #(
    parameter int DATA_W  = 12,
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 8
) (
    input logic          CLK,
    input logic          RST,
    dds_sin_gen_if.slave bus
);
    localparam int DEPTH = 1 << LUT_AW;
    localparam int M_W   = DATA_W - 1;
    localparam logic [DATA_W-1:0] MID = {1'b1, {M_W{1'b0}}};

    // Quarter-wave table sampled at bin centres so the four quadrants mirror exactly.
    function automatic logic [DEPTH*M_W-1:0] rom_init();
        logic [DEPTH*M_W-1:0] bits;
        real                  amp;
        real                  ang;
        int                   v;
        bits = '0;
        amp  = $itor((1 << M_W) - 1);
        for (int i = 0; i < DEPTH; i++) begin
            ang = 3.14159265358979323846 / 2.0 * ($itor(i) + 0.5) / $itor(DEPTH);
            v   = $rtoi(amp * $sin(ang) + 0.5);
            bits[i*M_W +: M_W] = M_W'(v);
        end
        return bits;
    endfunction

    localparam logic [DEPTH*M_W-1:0] ROM_BITS = rom_init();

    logic [M_W-1:0] rom [DEPTH];
    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom[g] = ROM_BITS[g*M_W +: M_W];
    end

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] ftw_act;
    logic [PHASE_W-1:0] ftw_shadow;
    logic               pend;
    logic               first;
    logic               carry_prev;

    logic [PHASE_W:0]   sum;
    logic               wrap_now;
    logic               swap;
    logic [1:0]         p_q;
    logic [LUT_AW-1:0]  p_a;

    // Next-phase add and the period-aligned tuning-word swap decision.
    always_comb begin
        sum      = {1'b0, acc} + {1'b0, ftw_act};
        wrap_now = sum[PHASE_W];
        swap     = bus.en && pend && (wrap_now || (ftw_act == '0));
        p_q      = acc[PHASE_W-1 -: 2];
        p_a      = acc[PHASE_W-3 -: LUT_AW];
    end

    // Accumulator, tuning-word shadow/active registers and wrap tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc        <= '0;
            ftw_act    <= '0;
            ftw_shadow <= '0;
            pend       <= 1'b0;
            first      <= 1'b1;
            carry_prev <= 1'b0;
        end else begin
            if (bus.ftw_load) begin
                ftw_shadow <= bus.ftw_in;
            end
            if (swap) begin
                ftw_act <= bus.ftw_load ? bus.ftw_in : ftw_shadow;
                pend    <= 1'b0;
            end else if (bus.ftw_load) begin
                pend <= 1'b1;
            end
            if (bus.en) begin
                acc        <= sum[PHASE_W-1:0];
                carry_prev <= wrap_now;
                first      <= 1'b0;
            end
        end
    end

    logic              v1;
    logic              y1;
    logic [1:0]        q1;
    logic [LUT_AW-1:0] a1;
    logic              v2;
    logic              y2;
    logic [1:0]        q2;
    logic [M_W-1:0]    m2;
    logic [DATA_W-1:0] sin_r;
    logic              valid_r;
    logic              vsync_r;

    // Stage 1: split phase into quadrant and mirrored quarter-wave address.
    always_ff @(posedge CLK) begin
        if (RST) begin
            v1 <= 1'b0;
            y1 <= 1'b0;
            q1 <= '0;
            a1 <= '0;
        end else begin
            v1 <= bus.en;
            y1 <= bus.en && (carry_prev || first);
            if (bus.en) begin
                q1 <= p_q;
                a1 <= p_q[0] ? ~p_a : p_a;
            end
        end
    end

    // Stage 2: quarter-wave ROM read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            v2 <= 1'b0;
            y2 <= 1'b0;
            q2 <= '0;
            m2 <= '0;
        end else begin
            v2 <= v1;
            y2 <= y1;
            if (v1) begin
                q2 <= q1;
                m2 <= rom[a1];
            end
        end
    end

    // Stage 3: fold magnitude into offset-binary; output holds between samples.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sin_r   <= MID;
            valid_r <= 1'b0;
            vsync_r <= 1'b0;
        end else begin
            valid_r <= v2;
            vsync_r <= y2;
            if (v2) begin
                sin_r <= q2[1] ? (MID - {1'b0, m2}) : (MID + {1'b0, m2});
            end
        end
    end

    assign bus.sin_data  = sin_r;
    assign bus.sin_valid = valid_r;
    assign bus.VSYNC     = vsync_r;

`ifdef DDS_QUAD_EN
    logic [1:0]        qc1;
    logic [LUT_AW-1:0] ac1;
    logic [1:0]        qc2;
    logic [M_W-1:0]    mc2;
    logic [DATA_W-1:0] cos_r;
    logic [1:0]        pc_q;

    // Cosine is the same phase advanced by a quarter turn: quadrant + 1.
    always_comb begin
        pc_q = p_q + 2'd1;
    end

    // Quadrature path, stage-for-stage aligned with the sine path.
    always_ff @(posedge CLK) begin
        if (RST) begin
            qc1   <= '0;
            ac1   <= '0;
            qc2   <= '0;
            mc2   <= '0;
            cos_r <= MID;
        end else begin
            if (bus.en) begin
                qc1 <= pc_q;
                ac1 <= pc_q[0] ? ~p_a : p_a;
            end
            if (v1) begin
                qc2 <= qc1;
                mc2 <= rom[ac1];
            end
            if (v2) begin
                cos_r <= qc2[1] ? (MID - {1'b0, mc2}) : (MID + {1'b0, mc2});
            end
        end
    end

    assign bus.cos_data = cos_r;
`endif
endmodule

// File: tb/tb_dds_sin_gen.sv
// tb/tb_dds_sin_gen.sv - self-checking bench for dds_sin_gen (honours DDS_QUAD_EN)
module tb_dds_sin_gen;
    localparam int DATA_W  = 12;
    localparam int PHASE_W = 24;
    localparam int LUT_AW  = 8;
    localparam int MID     = 2048;
    localparam longint unsigned MODV = 64'd1 << PHASE_W;
    localparam real PI = 3.14159265358979323846;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    dds_sin_gen_if #(.DATA_W(DATA_W), .PHASE_W(PHASE_W)) bus();

    dds_sin_gen #(.DATA_W(DATA_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Full-circle sine at the centre of the phase bin selected by the top bits.
    function automatic int ref_sample(input longint unsigned p);
        int  idx;
        real s;
        int  mag;
        idx = int'((p % MODV) >> (PHASE_W - LUT_AW - 2));
        s   = $sin(2.0 * PI * ($itor(idx) + 0.5) / $itor(1 << (LUT_AW + 2)));
        mag = $rtoi((s < 0.0 ? -s : s) * 2047.0 + 0.5);
        return (s < 0.0) ? MID - mag : MID + mag;
    endfunction

    typedef struct {
        int data;
        int cosv;
        bit vs;
        int cyc;
    } samp_t;

    samp_t exp_q[$];
    int    cyc = 0;
    int    last_data = MID;
    int    last_cos = MID;

    longint unsigned m_acc = 0, m_act = 0, m_shadow = 0;
    bit m_pend = 0, m_first = 1, m_carry = 0;

    // Reference model: advances phase by the active word and issues expected samples.
    always @(posedge CLK) begin
        longint unsigned nxt;
        bit wrapped;
        bit do_swap;
        samp_t s;
        cyc++;
        if (RST) begin
            m_acc = 0; m_act = 0; m_shadow = 0;
            m_pend = 0; m_first = 1; m_carry = 0;
            exp_q.delete();
            last_data = MID;
            last_cos = MID;
        end else begin
            nxt = m_acc + m_act;
            wrapped = (nxt >= MODV);
            if (bus.en) begin
                s.data = ref_sample(m_acc);
                s.cosv = ref_sample(m_acc + MODV / 4);
                s.vs   = m_carry || m_first;
                s.cyc  = cyc;
                exp_q.push_back(s);
            end
            do_swap = bus.en && m_pend && (wrapped || m_act == 0);
            if (bus.ftw_load) m_shadow = longint'(bus.ftw_in);
            if (do_swap) begin
                m_act = m_shadow;
                m_pend = 0;
            end else if (bus.ftw_load) begin
                m_pend = 1;
            end
            if (bus.en) begin
                m_acc = nxt % MODV;
                m_carry = wrapped;
                m_first = 0;
            end
        end
    end

    int cap_d[$];
    bit cap_v[$];

    // Scoreboard plus capture of every valid output sample.
    always @(negedge CLK) begin
        bit ev;
        samp_t s;
        ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc - 2);
        check("sb_valid", bus.sin_valid, ev);
        if (ev) begin
            s = exp_q.pop_front();
            check("sb_data", bus.sin_data, s.data);
            check("sb_vsync", bus.VSYNC, s.vs);
`ifdef DDS_QUAD_EN
            check("sb_cos", bus.cos_data, s.cosv);
            last_cos = s.cosv;
`endif
            last_data = s.data;
        end else begin
            check("sb_vsync_idle", bus.VSYNC, 1'b0);
            check("sb_hold", bus.sin_data, last_data);
`ifdef DDS_QUAD_EN
            check("sb_cos_hold", bus.cos_data, last_cos);
`endif
        end
        if (bus.sin_valid === 1'b1) begin
            cap_d.push_back(int'(bus.sin_data));
            cap_v.push_back(bus.VSYNC);
        end
    end

    task automatic start_run(input logic [PHASE_W-1:0] ftw);
        RST = 1'b1; bus.en = 1'b0; bus.ftw_load = 1'b0;
        @(negedge CLK);
        RST = 1'b0; bus.ftw_in = ftw; bus.ftw_load = 1'b1;
        @(negedge CLK);
        bus.ftw_load = 1'b0; bus.en = 1'b1;
        cap_d.delete();
        cap_v.delete();
    endtask

    task automatic wait_caps(input int n);
        int t;
        t = 0;
        while (cap_d.size() < n && t < n + 20) begin
            @(negedge CLK);
            t++;
        end
        if (cap_d.size() < n) check("cap_timeout", cap_d.size(), n);
    endtask

    typedef struct {
        logic [PHASE_W-1:0] ftw;
        int k;
        int exp_d;
        bit exp_v;
    } vec_t;

    vec_t tbl[16];
    int   pos[$];
    int   w2[3];
    int   w3[4];

    initial begin
        // phase sample k of a fresh run lands at capture index k+1
        tbl[0]  = '{24'h004000,    0, 12'h806, 1'b0};
        tbl[1]  = '{24'h004000,  255, 12'hFFF, 1'b0};
        tbl[2]  = '{24'h004000,  256, 12'hFFF, 1'b0};
        tbl[3]  = '{24'h004000,  511, 12'h806, 1'b0};
        tbl[4]  = '{24'h004000,  512, 12'h7FA, 1'b0};
        tbl[5]  = '{24'h004000,  767, 12'h001, 1'b0};
        tbl[6]  = '{24'h004000,  768, 12'h001, 1'b0};
        tbl[7]  = '{24'h004000, 1024, 12'h806, 1'b1};
        tbl[8]  = '{24'h008000,  128, 12'hFFF, 1'b0};
        tbl[9]  = '{24'h008000,  256, 12'h7FA, 1'b0};
        tbl[10] = '{24'h008000,  512, 12'h806, 1'b1};
        tbl[11] = '{24'hC00000,    1, 12'h001, 1'b0};
        tbl[12] = '{24'hC00000,    2, 12'h7FA, 1'b1};
        tbl[13] = '{24'hC00000,    3, 12'hFFF, 1'b1};
        tbl[14] = '{24'h004001,    1, 12'h813, 1'b0};
        tbl[15] = '{24'h004001,    0, 12'h806, 1'b0};
        w2 = '{0, 1025, 2049};
        w3 = '{0, 1025, 1537, 2049};

        bus.en = 1'b1; bus.ftw_in = '0; bus.ftw_load = 1'b0;

        // reset held two cycles with en high, then first sample 3 cycles later
        repeat (2) @(negedge CLK);
        check("rst_data", bus.sin_data, 12'h800);
        check("rst_valid", bus.sin_valid, 1'b0);
        check("rst_vsync", bus.VSYNC, 1'b0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("lat_valid_early", bus.sin_valid, 1'b0);
        @(negedge CLK);
        check("first_valid", bus.sin_valid, 1'b1);
        check("first_data", bus.sin_data, 12'h806);
        check("first_vsync", bus.VSYNC, 1'b1);

        for (int i = 0; i < 16; i++) begin
            start_run(tbl[i].ftw);
            wait_caps(tbl[i].k + 2);
            if (cap_d.size() >= tbl[i].k + 2) begin
                check($sformatf("tbl%0d_data", i), cap_d[tbl[i].k + 1], tbl[i].exp_d);
                check($sformatf("tbl%0d_vsync", i), cap_v[tbl[i].k + 1], tbl[i].exp_v);
            end
        end

        // steady 0x4000: period length and half-period symmetry
        start_run(24'h004000);
        wait_caps(2060);
        pos.delete();
        foreach (cap_v[i]) if (cap_v[i]) pos.push_back(i);
        check("per_count", pos.size(), 3);
        for (int i = 0; i < 3 && i < pos.size(); i++) check($sformatf("per_pos%0d", i), pos[i], w2[i]);
        for (int n = 0; n < 512; n++) begin
            check($sformatf("sym_sum%0d", n), cap_d[1 + n] + cap_d[1 + n + 512], 4096);
            if (n < 256) check($sformatf("mirror%0d", n), cap_d[1 + n], cap_d[1 + 511 - n]);
        end

        // retune mid-period: current period completes, later periods halve
        start_run(24'h004000);
        wait_caps(302);
        bus.ftw_in = 24'h008000; bus.ftw_load = 1'b1;
        @(negedge CLK);
        bus.ftw_load = 1'b0;
        wait_caps(2060);
        pos.delete();
        foreach (cap_v[i]) if (cap_v[i]) pos.push_back(i);
        check("retune_count", pos.size(), 4);
        for (int i = 0; i < 4 && i < pos.size(); i++) check($sformatf("retune_pos%0d", i), pos[i], w3[i]);

        // en gaps: valid follows en delayed by 3
        bus.en = 1'b0;
        repeat (4) @(negedge CLK);
        begin
            bit pat[7];
            pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            for (int i = 0; i < 7; i++) begin
                check($sformatf("gap_valid%0d", i), bus.sin_valid, (i >= 3) ? pat[i-3] : 1'b0);
                bus.en = pat[i];
                @(negedge CLK);
            end
        end

        // reset with samples in flight
        bus.en = 1'b1;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_valid", bus.sin_valid, 1'b0);
        check("midrst_data", bus.sin_data, 12'h800);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("restart_valid", bus.sin_valid, 1'b1);
        check("restart_data", bus.sin_data, 12'h806);
        check("restart_vsync", bus.VSYNC, 1'b1);
`ifdef DDS_QUAD_EN
        check("restart_cos", bus.cos_data, 12'hFFF);
`endif

        // randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            RST = ($urandom_range(0, 599) == 0);
            bus.en = ($urandom_range(0, 3) != 0);
            bus.ftw_load = ($urandom_range(0, 47) == 0);
            bus.ftw_in = ($urandom_range(0, 3) == 0) ? PHASE_W'($urandom) : PHASE_W'($urandom_range(1, 32'h40000));
            @(negedge CLK);
        end
        RST = 1'b0; bus.en = 1'b0; bus.ftw_load = 1'b0;
        repeat (5) @(negedge CLK);
        check("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
